// File: rtl/waveform_pkg.sv
// Shared waveform-select encoding for the multi-waveform generator and its users.
package waveform_pkg;

    typedef enum logic [1:0] {
        SINE  = 2'd0,
        PULSE = 2'd1,
        SAW   = 2'd2,
        TRI   = 2'd3
    } waveform_e;

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with a registered read; entry i holds
// round(sin(i*pi/(2*DEPTH)) * (2^DATA_WIDTH - 1)) as an unsigned magnitude.
module sine_quarter_rom #(
    parameter int TABLE_ADDR_WIDTH = 11,
    parameter int DATA_WIDTH       = 15
) (
    input  logic                        i_Clock,
    input  logic [TABLE_ADDR_WIDTH-1:0] i_Address,
    output logic [DATA_WIDTH-1:0]       o_Data
);

    localparam int DEPTH = 1 << TABLE_ADDR_WIDTH;
    localparam longint HALF_PI_Q30 = 64'd1686629713;

    // Contents are fixed at elaboration with a Q30 Taylor series, so the
    // memory is never written and maps onto a block ROM.
    function automatic logic [DEPTH-1:0][DATA_WIDTH-1:0] buildTable();
        logic [DEPTH-1:0][DATA_WIDTH-1:0] tbl;
        longint x, x2, term, sum, amp, val;
        amp = (longint'(1) << DATA_WIDTH) - 1;
        for (int i = 0; i < DEPTH; i++) begin
            x    = (longint'(i) * HALF_PI_Q30) / longint'(DEPTH);
            x2   = (x * x) >>> 30;
            term = x;
            sum  = x;
            for (int k = 1; k <= 6; k++) begin
                term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
                sum  = sum + term;
            end
            val = (sum * amp + (longint'(1) << 29)) >>> 30;
            if (val > amp) val = amp;
            if (val < 0) val = 0;
            tbl[TABLE_ADDR_WIDTH'(i)] = DATA_WIDTH'(val);
        end
        return tbl;
    endfunction

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_Rom = buildTable();

    always_ff @(posedge i_Clock) begin
        o_Data <= r_Rom[i_Address];
    end

endmodule

// File: rtl/multi_waveform_generator.sv
// Three-stage pipelined sine/pulse/sawtooth/triangle generator driven by an
// external phase, with a channel tag carried alongside each sample.
module multi_waveform_generator
    import waveform_pkg::*;
#(
    parameter int PHASE_WIDTH  = 13,
    parameter int OUT_WIDTH    = 16,
    parameter int CHANNEL_BITS = 5
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic                           i_Valid,
    input  logic [PHASE_WIDTH-1:0]         i_Phase,
    input  logic [1:0]                     i_Waveform,
    input  logic [PHASE_WIDTH-1:0]         i_Duty,
    input  logic [CHANNEL_BITS-1:0]        i_Channel,
    output logic                           o_Valid,
    output logic [CHANNEL_BITS-1:0]        o_Channel,
    output logic signed [OUT_WIDTH-1:0]    o_Amplitude
);

    localparam int TABLE_ADDR_WIDTH = PHASE_WIDTH - 2;
    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MAX_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                        r_Valid1, r_Valid2;
    logic [CHANNEL_BITS-1:0]     r_Channel1, r_Channel2;
    waveform_e                   r_Mode1, r_Mode2;
    logic                        r_Negate1, r_Negate2;
    logic [TABLE_ADDR_WIDTH-1:0] r_Index1;
    logic [PHASE_WIDTH-1:0]      r_Phase1, r_Duty1;
    logic [OUT_WIDTH-1:0]        r_Pulse2, r_Saw2, r_Tri2;

    logic [OUT_WIDTH-2:0]        w_RomData;
    logic [OUT_WIDTH-1:0]        w_Sine;
    logic [PHASE_WIDTH-1:0]      w_SawRaw;
    logic [PHASE_WIDTH-2:0]      w_Fold, w_TriRaw;

    // Only the valid bits are reset; payload registers just follow their inputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Valid1 <= 1'b0;
            r_Valid2 <= 1'b0;
        end else begin
            r_Valid1 <= i_Valid;
            r_Valid2 <= r_Valid1;
        end
    end

    // Mirroring the phase into the first quadrant makes the quarter table cover a full period.
    always_ff @(posedge i_Clock) begin
        r_Channel1 <= i_Channel;
        r_Mode1    <= waveform_e'(i_Waveform);
        r_Phase1   <= i_Phase;
        r_Duty1    <= i_Duty;
        r_Negate1  <= i_Phase[PHASE_WIDTH-1];
        r_Index1   <= i_Phase[PHASE_WIDTH-2] ? ~i_Phase[TABLE_ADDR_WIDTH-1:0]
                                             :  i_Phase[TABLE_ADDR_WIDTH-1:0];
    end

    sine_quarter_rom #(
        .TABLE_ADDR_WIDTH (TABLE_ADDR_WIDTH),
        .DATA_WIDTH       (OUT_WIDTH - 1)
    ) u_SineRom (
        .i_Clock   (i_Clock),
        .i_Address (r_Index1),
        .o_Data    (w_RomData)
    );

    assign w_SawRaw = {~r_Phase1[PHASE_WIDTH-1], r_Phase1[PHASE_WIDTH-2:0]};
    assign w_Fold   = r_Phase1[PHASE_WIDTH-1] ? ~r_Phase1[PHASE_WIDTH-2:0]
                                              :  r_Phase1[PHASE_WIDTH-2:0];
    assign w_TriRaw = {~w_Fold[PHASE_WIDTH-2], w_Fold[PHASE_WIDTH-3:0]};

    // Appending OUT_WIDTH zeros then dropping the original width left-justifies
    // the value, padding or truncating LSBs as the widths require.
    always_ff @(posedge i_Clock) begin
        r_Channel2 <= r_Channel1;
        r_Mode2    <= r_Mode1;
        r_Negate2  <= r_Negate1;
        r_Pulse2   <= (r_Phase1 < r_Duty1) ? MAX_POS : MAX_NEG;
        r_Saw2     <= OUT_WIDTH'({w_SawRaw, {OUT_WIDTH{1'b0}}} >> PHASE_WIDTH);
        r_Tri2     <= OUT_WIDTH'({w_TriRaw, {OUT_WIDTH{1'b0}}} >> (PHASE_WIDTH - 1));
    end

    assign w_Sine = r_Negate2 ? ~{1'b0, w_RomData} : {1'b0, w_RomData};

    // Outputs only update on a valid sample, otherwise they hold the last one.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Valid     <= 1'b0;
            o_Channel   <= '0;
            o_Amplitude <= '0;
        end else begin
            o_Valid <= r_Valid2;
            if (r_Valid2) begin
                o_Channel <= r_Channel2;
                case (r_Mode2)
                    SINE:  o_Amplitude <= w_Sine;
                    PULSE: o_Amplitude <= r_Pulse2;
                    SAW:   o_Amplitude <= r_Saw2;
                    TRI:   o_Amplitude <= r_Tri2;
                endcase
            end
        end
    end

endmodule
